datagram_link_rx: RTL and testbench

//  Serial receiver on each display board. Recovers the MESSAGE_SIZE-bit datagram the core board broadcasts

---
 rtl/datagram_link_rx_pkg.sv | 17 +
 rtl/datagram_link_rx_if.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/datagram_link_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_datagram_link_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/datagram_link_rx_pkg.sv
// Shared constants and types for the display-board datagram link receiver.
package datagram_link_rx_pkg;

    localparam int MESSAGE_SIZE      = 16;
    localparam int LINK_CLKS_PER_BIT = 100;
    localparam int LINK_TIMEOUT      = 2_000_000;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/datagram_link_rx_if.sv
// Serial-in / datagram-out bundle between the link receiver and its surroundings.
interface datagram_link_rx_if #(
    parameter int MSG_W = datagram_link_rx_pkg::MESSAGE_SIZE
);
    logic             rx_serial;
    logic             vsync;
    logic [MSG_W-1:0] datagram;
    logic             frame_ok;
    logic             parity_err;
    logic             framing_err;
    logic             link_alive;

    modport master (
        output rx_serial, vsync,
        input  datagram, frame_ok, parity_err, framing_err, link_alive
    );

    modport slave (
        input  rx_serial, vsync,
        output datagram, frame_ok, parity_err, framing_err, link_alive
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/datagram_link_rx.sv
// UART-style datagram receiver with even parity, break handling, vsync-aligned
// double buffering and a link-alive watchdog.
module datagram_link_rx
    import datagram_link_rx_pkg::*;
#(
    parameter int MSG_W        = MESSAGE_SIZE,
    parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT,
    parameter int VSYNC_COMMIT = 1,
    parameter int LINK_TIMEOUT_CYC = LINK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    datagram_link_rx_if.slave  bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(MSG_W + 1);
    localparam int TMO_W  = $clog2(LINK_TIMEOUT_CYC + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(MSG_W - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(LINK_TIMEOUT_CYC);

    logic [1:0] async_in;
    logic [1:0] synced;
    logic       rx_s;
    logic       vs_s;

    assign async_in = {bus.vsync, bus.rx_serial};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            sync_2ff #(.RST_VAL(1'b1)) u_sync (
                .clk (clk),
                .rst (rst),
                .d_i (async_in[gi]),
                .q_o (synced[gi])
            );
        end
    endgenerate

    assign rx_s = synced[0];
    assign vs_s = synced[1];

    rx_state_t         state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [BIT_W-1:0]  bit_q,    bit_d;
    logic [MSG_W-1:0]  shift_q,  shift_d;
    logic              par_q,    par_d;
    logic              frame_good;
    logic              par_bad;
    logic              frame_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_good = 1'b0;
        par_bad    = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end
            end
            RX_START: begin
                // Half-period recheck rejects short glitches without raising an error.
                if (baud_q == BAUD_HALF) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[MSG_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = RX_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    par_d   = rx_s;
                    state_d = RX_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        frame_bad = 1'b1;
                        state_d   = RX_BREAK;
                    end else if ((^shift_q) ^ par_q) begin
                        par_bad = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_good = 1'b1;
                        state_d    = RX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    logic             frame_ok_q;
    logic             parity_err_q;
    logic             framing_err_q;
    logic             link_alive_q;
    logic [TMO_W-1:0] tmo_q;
    logic             vs_prev_q;
    logic             vs_fall_q;
    logic [MSG_W-1:0] datagram_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_ok_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            link_alive_q  <= 1'b0;
            tmo_q         <= '0;
            vs_prev_q     <= 1'b1;
            vs_fall_q     <= 1'b0;
        end else begin
            frame_ok_q    <= frame_good;
            parity_err_q  <= par_bad;
            framing_err_q <= frame_bad;
            vs_prev_q     <= vs_s;
            vs_fall_q     <= vs_prev_q & ~vs_s;
            if (frame_good) begin
                tmo_q        <= TMO_LOAD;
                link_alive_q <= 1'b1;
            end else if (tmo_q == '0) begin
                link_alive_q <= 1'b0;
            end else begin
                tmo_q <= tmo_q - 1'b1;
            end
        end
    end

    generate
        if (VSYNC_COMMIT != 0) begin : g_vsync_commit
            logic [MSG_W-1:0] shadow_q;
            logic             pending_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_q   <= '0;
                    pending_q  <= 1'b0;
                    datagram_q <= '0;
                end else if (frame_good && vs_fall_q) begin
                    // Frame lands on the commit cycle itself: show it now, skip the shadow.
                    datagram_q <= shift_q;
                    pending_q  <= 1'b0;
                end else begin
                    if (frame_good) begin
                        shadow_q  <= shift_q;
                        pending_q <= 1'b1;
                    end
                    if (vs_fall_q && pending_q) begin
                        datagram_q <= shadow_q;
                        pending_q  <= 1'b0;
                    end
                end
            end
        end else begin : g_direct_commit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    datagram_q <= '0;
                end else if (frame_ok_q) begin
                    datagram_q <= shift_q;
                end
            end
        end
    endgenerate

    assign bus.datagram    = datagram_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.framing_err = framing_err_q;
    assign bus.link_alive  = link_alive_q;
endmodule

// File: tb/tb_datagram_link_rx.sv
// Scoreboard bench for datagram_link_rx: pulse events and datagram commits are
// predicted when stimulus is driven and checked as the receiver produces them.
module tb_datagram_link_rx;
    import datagram_link_rx_pkg::*;

    localparam int MSG_W = 16;
    localparam int CPB   = 8;
    localparam int TMO   = 1000;

    localparam logic [1:0] EV_OK  = 2'd1;
    localparam logic [1:0] EV_PAR = 2'd2;
    localparam logic [1:0] EV_FRM = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    datagram_link_rx_if #(.MSG_W(MSG_W)) bus();

    datagram_link_rx #(
        .MSG_W            (MSG_W),
        .CLKS_PER_BIT     (CPB),
        .VSYNC_COMMIT     (1),
        .LINK_TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int last_ok_cyc = 0;

    logic [1:0]       exp_ev[$];
    logic [MSG_W-1:0] exp_dg[$];
    logic [MSG_W-1:0] m_shadow  = '0;
    logic             m_pending = 1'b0;
    logic [MSG_W-1:0] m_dg      = '0;
    logic [MSG_W-1:0] dg_prev   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] mon_ev;
    int         mon_n;
    always @(negedge clk) begin
        if (rst) begin
            mon_n = int'(bus.frame_ok) + int'(bus.parity_err) + int'(bus.framing_err);
            if (mon_n != 0) begin
                chk("pulse_excl", mon_n, 1);
                mon_ev = bus.frame_ok ? EV_OK : (bus.parity_err ? EV_PAR : EV_FRM);
                if (bus.frame_ok) last_ok_cyc = cyc;
                $display("[%0d] pulse ev=%0d", cyc, mon_ev);
                if (exp_ev.size() == 0) chk("pulse_unexp", mon_ev, 0);
                else chk("pulse", mon_ev, exp_ev.pop_front());
            end
            if (bus.datagram !== dg_prev) begin
                $display("[%0d] commit datagram=%h", cyc, bus.datagram);
                if (exp_dg.size() == 0) chk("dg_unexp", bus.datagram, dg_prev);
                else chk("dg_commit", bus.datagram, exp_dg.pop_front());
            end
        end
        dg_prev = bus.datagram;
    end

    task automatic send_frame(input logic [MSG_W-1:0] d, input logic par, input logic stop);
        if (!stop) exp_ev.push_back(EV_FRM);
        else if (par != ^d) exp_ev.push_back(EV_PAR);
        else begin
            exp_ev.push_back(EV_OK);
            m_shadow  = d;
            m_pending = 1'b1;
        end
        @(posedge clk); #1 bus.rx_serial = 1'b0;
        for (int i = 0; i < MSG_W; i++) begin
            repeat (CPB) @(posedge clk);
            #1 bus.rx_serial = d[i];
        end
        repeat (CPB) @(posedge clk); #1 bus.rx_serial = par;
        repeat (CPB) @(posedge clk); #1 bus.rx_serial = stop;
        repeat (CPB) @(posedge clk); #1;
    endtask

    task automatic vsync_pulse(input logic check_timing);
        logic [MSG_W-1:0] old_dg;
        logic [MSG_W-1:0] new_dg;
        old_dg = m_dg;
        new_dg = m_pending ? m_shadow : m_dg;
        @(posedge clk); #1 bus.vsync = 1'b0;
        if (m_pending) begin
            exp_dg.push_back(m_shadow);
            m_pending = 1'b0;
        end
        m_dg = new_dg;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (check_timing) chk("commit_edge3_old", bus.datagram, old_dg);
        @(posedge clk);
        @(negedge clk);
        if (check_timing) chk("commit_edge4_new", bus.datagram, new_dg);
        repeat (4) @(posedge clk); #1 bus.vsync = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_serial = 1'b1;
        bus.vsync     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_datagram", bus.datagram, 0);
        chk("rst_frame_ok", bus.frame_ok, 0);
        chk("rst_parity_err", bus.parity_err, 0);
        chk("rst_framing_err", bus.framing_err, 0);
        chk("rst_link_alive", bus.link_alive, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(posedge clk);

        // Good frame, then a vsync commit with exact latency.
        send_frame(16'hA5C3, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_link_alive", bus.link_alive, 1);
        vsync_pulse(1'b1);

        // Wrong parity: dropped, nothing to commit.
        send_frame(16'h0001, 1'b0, 1'b1);
        vsync_pulse(1'b0);
        chk("t2_datagram_held", bus.datagram, 16'hA5C3);

        // Framing error followed by a long break.
        send_frame(16'h1234, 1'b1, 1'b0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("t3_in_break", int'(dut.state_q), int'(RX_BREAK));
        @(posedge clk); #1 bus.rx_serial = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t3_break_exit", int'(dut.state_q), int'(RX_IDLE));

        // Idle-line glitch, then two frames before a single vsync.
        @(posedge clk); #1 bus.rx_serial = 1'b0;
        repeat (2) @(posedge clk); #1 bus.rx_serial = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t4_glitch_idle", int'(dut.state_q), int'(RX_IDLE));
        send_frame(16'h00FF, 1'b0, 1'b1);
        send_frame(16'hFF00, 1'b0, 1'b1);
        vsync_pulse(1'b0);
        chk("t4_newest_shown", bus.datagram, 16'hFF00);

        // Frame completion coincides with the commit strobe.
        fork
            send_frame(16'hBEEF, 1'b1, 1'b1);
            begin
                @(posedge clk);
                repeat (147) @(posedge clk);
                #1 bus.vsync = 1'b0;
                if (m_pending) begin
                    exp_dg.push_back(m_shadow);
                    m_pending = 1'b0;
                    m_dg      = m_shadow;
                end
                repeat (8) @(posedge clk); #1 bus.vsync = 1'b1;
            end
            begin
                @(posedge clk);
                repeat (151) @(posedge clk);
                @(negedge clk);
                chk("t5_bypass_dg", bus.datagram, 16'hBEEF);
                chk("t5_bypass_ok", bus.frame_ok, 1);
            end
        join
        repeat (4) @(posedge clk);
        vsync_pulse(1'b0);
        chk("t5_second_vsync", bus.datagram, 16'hBEEF);

        // Reset in the middle of a data phase.
        @(posedge clk); #1 bus.rx_serial = 1'b0;
        repeat (CPB * 4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_datagram", bus.datagram, 0);
        chk("t6_rst_link", bus.link_alive, 0);
        chk("t6_rst_frame_ok", bus.frame_ok, 0);
        chk("t6_rst_state", int'(dut.state_q), int'(RX_IDLE));
        m_dg      = '0;
        m_pending = 1'b0;
        bus.rx_serial = 1'b1;
        repeat (4) @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        chk("t6_ev_queue_empty", exp_ev.size(), 0);
        send_frame(16'h5A5A, 1'b0, 1'b1);
        vsync_pulse(1'b0);
        chk("t6_datagram", bus.datagram, 16'h5A5A);

        // Watchdog on the link after the last good frame.
        while (cyc < last_ok_cyc + TMO - 10) @(posedge clk);
        @(negedge clk);
        chk("t6_link_still_alive", bus.link_alive, 1);
        while (cyc < last_ok_cyc + TMO + 10) @(posedge clk);
        @(negedge clk);
        chk("t6_link_dropped", bus.link_alive, 0);

        repeat (4) @(posedge clk);
        chk("end_ev_queue", exp_ev.size(), 0);
        chk("end_dg_queue", exp_dg.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
